// File: rtl/imem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_arb_pkg
// Description : Shared types and constants for the instruction-memory fetch
//               arbiter. It holds the run/halt state encoding, the port
//               identifiers and the memory word size.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_arb_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_F = 1'b0,
        PORT_D = 1'b1
    } port_e;

    localparam int WORD_BYTES = 4;

endpackage : imem_arb_pkg
`default_nettype wire

// File: rtl/imem_addr_check.sv
`default_nettype none
// ============================================================================
// Module      : imem_addr_check
// Description : Decides whether a byte address names a whole, word-aligned
//               instruction word inside the memory. The compare is a plain
//               32-bit unsigned compare, so addresses near 2^32 cannot wrap
//               around into the legal range.
// Ports       : addr  in  32  byte address to check
//               legal out 1   1 = aligned and addr+3 < MEM_BYTES
// Parameters  : MEM_BYTES - memory capacity in bytes
// Revision    : 1.0 - initial release
// ============================================================================
module imem_addr_check
    import imem_arb_pkg::*;
#(
    parameter int MEM_BYTES = 128
) (
    input  logic [31:0] addr,
    output logic        legal
);

    // Highest byte address at which a full word still fits.
    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - WORD_BYTES);

    assign legal = (addr[1:0] == 2'b00) && (addr <= LAST_WORD);

endmodule : imem_addr_check
`default_nettype wire

// File: rtl/imem_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_arbiter
// Description : Shares the single combinational read port of the instruction
//               memory between the fetch unit (F) and the debug/boot port (D).
//               At most one access is granted per cycle and every response is
//               registered. Illegal addresses are answered with an error and
//               never reach the memory. A run/halt FSM lets debug stop fetch
//               traffic cleanly.
// Ports       : clk, rst_n (synchronous, active low)
//               f_req/f_addr -> f_gnt, f_rvalid/f_rdata/f_err   fetch port
//               d_req/d_addr -> d_gnt, d_rvalid/d_rdata/d_err   debug port
//               dbg_halt -> halted                              halt control
//               imem_req/imem_addr -> imem_data                 memory port
// Parameters  : MEM_BYTES    - memory capacity in bytes
//               STARVE_LIMIT - F grants allowed while D waits before D is
//                              forced (fixed-priority build only, >= 1)
// Config      : IMEM_ARB_RR_EN - when defined, round-robin arbitration
//               replaces fixed priority F>D and the starve counter.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_arbiter
    import imem_arb_pkg::*;
#(
    parameter int MEM_BYTES    = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    output logic        f_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    input  logic        dbg_halt,
    output logic        halted,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data
);

    arb_state_e  state;
    arb_state_e  state_next;

    logic        f_elig;
    logic        d_elig;
    logic        gnt_f;
    logic        gnt_d;
    logic [31:0] sel_addr;
    logic        addr_legal;

    logic        f_rvalid_q;
    logic        f_err_q;
    logic [31:0] f_rdata_q;
    logic        d_rvalid_q;
    logic        d_err_q;
    logic [31:0] d_rdata_q;

    // Everything is qualified by rst_n so that outputs read as zero for the
    // whole reset window, including its first cycle, and a response whose
    // grant was followed by reset is never presented.
    // F stops in the very cycle dbg_halt is seen, before the FSM moves.
    assign f_elig = rst_n && f_req && (state == RUN) && !dbg_halt;
    assign d_elig = rst_n && d_req;

`ifdef IMEM_ARB_RR_EN
    // rr_ptr names the port that wins the next contested cycle; it flips to
    // the other port on every grant.
    port_e rr_ptr;

    always_comb begin
        gnt_f = 1'b0;
        gnt_d = 1'b0;
        if (f_elig && d_elig) begin
            gnt_f = (rr_ptr == PORT_F);
            gnt_d = (rr_ptr == PORT_D);
        end else begin
            gnt_f = f_elig;
            gnt_d = d_elig;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= PORT_F;
        end else if (gnt_f) begin
            rr_ptr <= PORT_D;
        end else if (gnt_d) begin
            rr_ptr <= PORT_F;
        end
    end
`else
    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    // Once D has watched STARVE_LIMIT fetch grants go by, it overrides F.
    assign starved = d_elig && (starve_cnt == CNT_MAX);

    always_comb begin
        gnt_f = f_elig && !starved;
        gnt_d = d_elig && (!f_elig || starved);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!d_req || gnt_d) begin
            starve_cnt <= '0;
        end else if (gnt_f && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

    assign f_gnt = gnt_f;
    assign d_gnt = gnt_d;

    // One checker on the muxed address serves whichever port was granted.
    assign sel_addr = gnt_d ? d_addr : f_addr;

    imem_addr_check #(
        .MEM_BYTES (MEM_BYTES)
    ) u_addr_check (
        .addr  (sel_addr),
        .legal (addr_legal)
    );

    assign imem_req  = (gnt_f || gnt_d) && addr_legal;
    assign imem_addr = imem_req ? sel_addr : 32'd0;

    // Response registers: rdata/err stay zero except in a response cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_rvalid_q <= 1'b0;
            f_err_q    <= 1'b0;
            f_rdata_q  <= '0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            f_rvalid_q <= gnt_f;
            f_err_q    <= gnt_f && !addr_legal;
            f_rdata_q  <= (gnt_f && addr_legal) ? imem_data : 32'd0;
            d_rvalid_q <= gnt_d;
            d_err_q    <= gnt_d && !addr_legal;
            d_rdata_q  <= (gnt_d && addr_legal) ? imem_data : 32'd0;
        end
    end

    assign f_rvalid = rst_n && f_rvalid_q;
    assign f_err    = rst_n && f_err_q;
    assign f_rdata  = rst_n ? f_rdata_q : 32'd0;
    assign d_rvalid = rst_n && d_rvalid_q;
    assign d_err    = rst_n && d_err_q;
    assign d_rdata  = rst_n ? d_rdata_q : 32'd0;

    // Run/halt FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // No F grant is possible outside RUN, so the only thing HALT_PEND can be
    // waiting for is the response of the last RUN-cycle grant.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (dbg_halt) begin
                    state_next = HALT_PEND;
                end
            end
            HALT_PEND: begin
                if (!dbg_halt) begin
                    state_next = RUN;
                end else if (!f_rvalid_q) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                if (!dbg_halt) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign halted = rst_n && (state == HALTED);

endmodule : imem_fetch_arbiter
`default_nettype wire

// File: tb/tb_imem_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_fetch_arbiter
// Description : Directed self-checking bench for imem_fetch_arbiter with
//               MEM_BYTES=128, STARVE_LIMIT=4. Inputs change 1 ns after the
//               rising edge, combinational outputs are checked 2 ns after it
//               and registered responses 1 ns after the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        f_err;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        dbg_halt;
    logic        halted;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    // Memory contents: each word is a fixed pattern of its address byte.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], ~a[7:0], 8'h3C, a[7:0] ^ 8'h5A};
    endfunction

    assign imem_data = mem_word(imem_addr);

    imem_fetch_arbiter #(
        .MEM_BYTES    (128),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .f_err     (f_err),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .dbg_halt  (dbg_halt),
        .halted    (halted),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_data (imem_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] t2_exp [3];
    logic [31:0] t4_addr [4];
    logic        t4_legal [4];
    logic [31:0] t4_data [4];
    logic [9:0]  pat;

    initial begin
        t2_exp  = '{32'h00FF3C5A, 32'h04FB3C5E, 32'h08F73C52};
        t4_addr = '{32'h0000_0002, 32'h0000_007C, 32'h0000_0080, 32'hFFFF_FFFC};
        t4_legal = '{1'b0, 1'b1, 1'b0, 1'b0};
        t4_data = '{32'h0, 32'h7C833C26, 32'h0, 32'h0};

        // 1: reset held with both requests pending
        rst_n    = 1'b0;
        f_req    = 1'b1;
        d_req    = 1'b1;
        f_addr   = 32'h0;
        d_addr   = 32'h4;
        dbg_halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check_eq("rst_f_gnt", f_gnt, 0);
            check_eq("rst_d_gnt", d_gnt, 0);
            check_eq("rst_imem_req", imem_req, 0);
            check_eq("rst_rvalid", {f_rvalid, d_rvalid}, 0);
            check_eq("rst_halted", halted, 0);
        end
        tick();
        rst_n = 1'b1;
        d_req = 1'b0;

        // 2: F-only back-to-back stream
        for (int i = 0; i < 3; i++) begin
            f_addr = 32'(i * 4);
            #1;
            check_eq("t2_f_gnt", f_gnt, 1);
            check_eq("t2_imem_addr", imem_addr, 32'(i * 4));
            tick();
            check_eq("t2_f_rvalid", f_rvalid, 1);
            check_eq("t2_f_rdata", f_rdata, t2_exp[i]);
            check_eq("t2_f_err", f_err, 0);
        end
        f_req = 1'b0;
        tick();
        check_eq("t2_idle_rvalid", f_rvalid, 0);
        check_eq("t2_idle_rdata", f_rdata, 0);

        // 3: both requesting continuously
`ifdef IMEM_ARB_RR_EN
        pat = 10'b1010101010;   // bit i = 1 -> F wins cycle i; D first after F history
`else
        pat = 10'b0111101111;   // F,F,F,F,D,F,F,F,F,D
`endif
        f_req  = 1'b1;
        d_req  = 1'b1;
        f_addr = 32'h0;
        d_addr = 32'h4;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("t3_f_gnt", f_gnt, pat[i]);
            check_eq("t3_d_gnt", d_gnt, !pat[i]);
            tick();
            check_eq("t3_f_rvalid", f_rvalid, pat[i]);
            check_eq("t3_d_rvalid", d_rvalid, !pat[i]);
            if (!pat[i]) check_eq("t3_d_rdata", d_rdata, 32'h04FB3C5E);
        end
        f_req = 1'b0;
        d_req = 1'b0;
        tick();

        // 4: debug accesses at legal/illegal boundaries
        d_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_addr = t4_addr[i];
            #1;
            check_eq("t4_d_gnt", d_gnt, 1);
            check_eq("t4_imem_req", imem_req, t4_legal[i]);
            check_eq("t4_imem_addr", imem_addr, t4_legal[i] ? t4_addr[i] : 32'h0);
            tick();
            check_eq("t4_d_rvalid", d_rvalid, 1);
            check_eq("t4_d_err", d_err, !t4_legal[i]);
            check_eq("t4_d_rdata", d_rdata, t4_data[i]);
        end
        d_req = 1'b0;
        tick();

        // 5: halt during an F stream, debug still served, then resume
        f_req  = 1'b1;
        f_addr = 32'h8;
        #1;
        check_eq("t5_f_gnt_run", f_gnt, 1);
        tick();
        dbg_halt = 1'b1;
        #1;
        check_eq("t5_f_gnt_drop", f_gnt, 0);
        check_eq("t5_last_f_rvalid", f_rvalid, 1);
        check_eq("t5_halted_run", halted, 0);
        tick();
        check_eq("t5_halted_pend", halted, 0);
        check_eq("t5_f_rvalid_pend", f_rvalid, 0);
        d_req  = 1'b1;
        d_addr = 32'h10;
        #1;
        check_eq("t5_d_gnt", d_gnt, 1);
        check_eq("t5_f_gnt_pend", f_gnt, 0);
        tick();
        check_eq("t5_halted", halted, 1);
        check_eq("t5_d_rdata", d_rdata, 32'h10EF3C4A);
        d_req = 1'b0;
        tick();
        check_eq("t5_halted_hold", halted, 1);
        dbg_halt = 1'b0;
        #1;
        check_eq("t5_f_gnt_halted", f_gnt, 0);
        tick();
        check_eq("t5_halted_clear", halted, 0);
        #1;
        check_eq("t5_f_gnt_resume", f_gnt, 1);
        tick();
        check_eq("t5_f_rvalid_resume", f_rvalid, 1);
        check_eq("t5_f_rdata_resume", f_rdata, 32'h08F73C52);

        // 6: reset the cycle after an F grant, while halt is requested
        f_addr = 32'h4;
        #1;
        check_eq("t6_f_gnt", f_gnt, 1);
        tick();
        rst_n    = 1'b0;
        dbg_halt = 1'b1;
        #1;
        check_eq("t6_f_rvalid_rst", f_rvalid, 0);
        check_eq("t6_f_gnt_rst", f_gnt, 0);
        tick();
        check_eq("t6_f_rvalid_after", f_rvalid, 0);
        check_eq("t6_halted_rst", halted, 0);
        tick();
        rst_n    = 1'b1;
        dbg_halt = 1'b0;
        #1;
        check_eq("t6_f_gnt_run", f_gnt, 1);
        tick();
        check_eq("t6_f_rvalid_run", f_rvalid, 1);
        check_eq("t6_f_rdata_run", f_rdata, 32'h04FB3C5E);
        f_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_imem_fetch_arbiter
`default_nettype wire
